// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and defaults for the program-counter/stack unit.
// Revision    : 1.0
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_REL  = 3'd2,
        OP_RET  = 3'd3,
        OP_CALL = 3'd4,
        OP_LD   = 3'd5
    } pc_op_e;

    localparam int unsigned PC_RESET_VEC = 0;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Return-address LIFO; ignores push when full, pop when empty.
// Revision    : 1.0
// ============================================================================
module ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [SP_W-1:0]  sp,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [SP_W-1:0]  w_sp_m1;

    assign full    = (sp_q == SP_W'(DEPTH));
    assign empty   = (sp_q == '0);
    assign sp      = sp_q;
    assign w_sp_m1 = sp_q - SP_W'(1);
    assign top_data = mem_q[IDX_W'(w_sp_m1)];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = w_sp_m1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entries carry no reset; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[IDX_W'(sp_q)] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : Program counter with load, relative branch and call/return stack.
// Revision    : 1.0
// ============================================================================
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned OFF_W       = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_VEC   = PC_RESET_VEC,
    parameter int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_enable,
    input  logic              ld,
    input  logic [ADDR_W-1:0] inp,
    input  logic              rel_en,
    input  logic [OFF_W-1:0]  offset,
    input  logic              call,
    input  logic              ret,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] out,
    output logic [SP_W-1:0]   sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int unsigned EXT_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

    pc_op_e              w_op;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                ovf_q;
    logic                ovf_d;
    logic                udf_q;
    logic                udf_d;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_rel;
    logic [ADDR_W-1:0]   w_top;
    logic signed [EXT_W-1:0] w_off_ext;
    logic                w_push;
    logic                w_pop;

    always_comb begin
        w_op = OP_HOLD;
        if (ld)             w_op = OP_LD;
        else if (call)      w_op = OP_CALL;
        else if (ret)       w_op = OP_RET;
        else if (rel_en)    w_op = OP_REL;
        else if (pc_enable) w_op = OP_INC;
    end

    // Sign-extend to the wider of the two widths, then keep the PC-width part.
    assign w_off_ext = EXT_W'($signed(offset));
    assign w_pc_inc  = pc_q + ADDR_W'(1);
    assign w_pc_rel  = pc_q + w_off_ext[ADDR_W-1:0];
    assign w_push    = (w_op == OP_CALL) && !stack_full;
    assign w_pop     = (w_op == OP_RET) && !stack_empty;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W),
        .SP_W  (SP_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc_d = pc_q;
        case (w_op)
            OP_LD:   pc_d = inp;
            OP_CALL: if (!stack_full)  pc_d = inp;
            OP_RET:  if (!stack_empty) pc_d = w_top;
            OP_REL:  pc_d = w_pc_rel;
            OP_INC:  pc_d = w_pc_inc;
            default: pc_d = pc_q;
        endcase
    end

    // A new error event outranks a simultaneous clear.
    assign ovf_d = ((w_op == OP_CALL) && stack_full)  || (ovf_q && !clr_err);
    assign udf_d = ((w_op == OP_RET)  && stack_empty) || (udf_q && !clr_err);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= ADDR_W'(RESET_VEC);
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign out     = pc_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack_unit
// Description : Directed plus random checks of pc_stack_unit against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_pc_stack_unit;

    logic       clk;
    logic       reset_n;
    logic       pc_enable;
    logic       ld;
    logic [7:0] inp;
    logic       rel_en;
    logic [7:0] offset;
    logic       call;
    logic       ret;
    logic       clr_err;
    logic [7:0] out;
    logic [2:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       udf_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf;
    logic       m_udf;

    pc_stack_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_enable   (pc_enable),
        .ld          (ld),
        .inp         (inp),
        .rel_en      (rel_en),
        .offset      (offset),
        .call        (call),
        .ret         (ret),
        .clr_err     (clr_err),
        .out         (out),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc  = 8'h00;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_edge();
        logic ovf_ev;
        logic udf_ev;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (ld) begin
            m_pc = inp;
        end else if (call) begin
            if (m_stk.size() == 4) begin
                ovf_ev = 1'b1;
            end else begin
                m_stk.push_back(8'((int'(m_pc) + 1) % 256));
                m_pc = inp;
            end
        end else if (ret) begin
            if (m_stk.size() == 0) udf_ev = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (rel_en) begin
            m_pc = 8'((int'(m_pc) + int'($signed(offset)) + 256) % 256);
        end else if (pc_enable) begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
        m_ovf = ovf_ev | (m_ovf & ~clr_err);
        m_udf = udf_ev | (m_udf & ~clr_err);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out"},   32'(out),         32'(m_pc));
        chk({tag, ".sp"},    32'(sp),          32'(m_stk.size()));
        chk({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == 4));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        chk({tag, ".udf"},   32'(udf_err),     32'(m_udf));
    endtask

    task automatic idle_inputs();
        pc_enable = 0; ld = 0; rel_en = 0; call = 0; ret = 0; clr_err = 0;
        inp = 8'h00; offset = 8'h00;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic do_ld(input logic [7:0] a);
        idle_inputs(); ld = 1; inp = a;
        cycle("ld");
    endtask

    task automatic do_call(input logic [7:0] a);
        idle_inputs(); call = 1; inp = a;
        cycle("call");
    endtask

    task automatic do_ret();
        idle_inputs(); ret = 1;
        cycle("ret");
    endtask

    task automatic do_rel(input logic [7:0] o);
        idle_inputs(); rel_en = 1; offset = o;
        cycle("rel");
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");

        // Reset release with increment
        reset_n = 1'b1;
        pc_enable = 1;
        for (int i = 0; i < 5; i++) cycle("inc");
        chk("inc5_abs", 32'(out), 32'h05);

        // Load priority over call and increment
        idle_inputs(); ld = 1; call = 1; pc_enable = 1; inp = 8'h18;
        cycle("ldprio");
        chk("ldprio_abs", 32'(out), 32'h18);
        idle_inputs(); pc_enable = 1;
        for (int i = 0; i < 3; i++) cycle("inc_after_ld");

        // Wraparound increment and relative branches
        do_ld(8'hFF);
        idle_inputs(); pc_enable = 1;
        cycle("wrap");
        chk("wrap_abs", 32'(out), 32'h00);
        do_ld(8'h10); do_rel(8'hFC);
        chk("rel_back_abs", 32'(out), 32'h0C);
        do_ld(8'h02); do_rel(8'hFC);
        chk("rel_wrap_abs", 32'(out), 32'hFE);
        do_ld(8'hF0); do_rel(8'h20);
        chk("rel_fwd_abs", 32'(out), 32'h10);

        // Nested calls to full, overflow, then unwind
        do_call(8'h40); do_call(8'h50); do_call(8'h60); do_call(8'h70);
        chk("full_abs", 32'(stack_full), 32'h1);
        do_call(8'h80);
        chk("ovf_pc_abs", 32'(out), 32'h70);
        chk("ovf_abs", 32'(ovf_err), 32'h1);
        do_ret(); chk("ret1_abs", 32'(out), 32'h61);
        do_ret(); do_ret(); do_ret();
        chk("ret4_abs", 32'(out), 32'h11);

        // Underflow, persistence, clear, clear-vs-set
        idle_inputs(); clr_err = 1; cycle("clr");
        do_ld(8'h22); do_ret();
        chk("udf_pc_abs", 32'(out), 32'h22);
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("udf_hold");
        idle_inputs(); clr_err = 1; cycle("udf_clr");
        chk("udf_clr_abs", 32'(udf_err), 32'h0);
        idle_inputs(); clr_err = 1; ret = 1; cycle("udf_setwins");
        chk("udf_setwins_abs", 32'(udf_err), 32'h1);

        // Asynchronous reset between edges with sp=2, then reset over a call edge
        do_call(8'h30); do_call(8'h38);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        idle_inputs(); call = 1; inp = 8'h55;
        @(posedge clk);
        #1;
        chk_all("rst_call");
        reset_n = 1'b1;
        do_ret();
        chk("udf_after_rst_abs", 32'(udf_err), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ld        = ($urandom_range(0, 15) == 0);
            call      = ($urandom_range(0, 3) == 0);
            ret       = ($urandom_range(0, 3) == 0);
            rel_en    = ($urandom_range(0, 3) == 0);
            pc_enable = ($urandom_range(0, 1) == 0);
            clr_err   = ($urandom_range(0, 7) == 0);
            inp       = 8'($urandom);
            offset    = 8'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
